ins_cache: RTL



---
 rtl/ins_cache_pkg.sv | 26 ++
 rtl/ins_cache_fsm.sv | 65 ++++++
 rtl/ins_cache.sv | 78 +++++++
 3 files changed

// File: rtl/ins_cache_pkg.sv
// Shared types and address-field geometry for the direct-mapped instruction cache.
package ins_cache_pkg;

    localparam int unsigned NUM_BLOCKS    = 8;
    localparam int unsigned TAG_BITS      = 3;
    localparam int unsigned INDEX_BITS    = 3;
    localparam int unsigned OFFSET_BITS   = 2;
    localparam int unsigned WORD_BITS     = 32;
    localparam int unsigned BLOCK_BITS    = 128;
    localparam int unsigned WORDS_PER_BLK = BLOCK_BITS / WORD_BITS;
    localparam int unsigned ADDR_BITS     = 10;
    localparam int unsigned MEM_ADDR_BITS = TAG_BITS + INDEX_BITS;

    localparam int unsigned OFFSET_LSB = 2;
    localparam int unsigned INDEX_LSB  = OFFSET_LSB + OFFSET_BITS;
    localparam int unsigned TAG_LSB    = INDEX_LSB + INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_e;

    typedef logic [WORDS_PER_BLK-1:0][WORD_BITS-1:0] block_t;

endpackage

// File: rtl/ins_cache_fsm.sv
// Miss-handling controller: runs one block read on the memory handshake, then a fill cycle.
module ins_cache_fsm
    import ins_cache_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   read,
    input  logic   hit,
    input  logic   mem_busywait,
    output state_e state,
    output logic   mem_read,
    output logic   latch_miss,
    output logic   fill_en
);

    state_e state_q;
    logic   first_cycle_q;
    logic   mem_read_q;
    logic   fill_en_q;

    assign latch_miss = (state_q == IDLE) & read & ~hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            first_cycle_q <= 1'b0;
            mem_read_q    <= 1'b0;
            fill_en_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (latch_miss) begin
                        state_q       <= MEM_READ;
                        first_cycle_q <= 1'b0;
                        mem_read_q    <= 1'b1;
                    end
                end
                MEM_READ: begin
                    // Memory's busywait is only trusted from the second edge onward.
                    if (!first_cycle_q) begin
                        first_cycle_q <= 1'b1;
                    end else if (!mem_busywait) begin
                        state_q    <= UPDATE;
                        mem_read_q <= 1'b0;
                        fill_en_q  <= 1'b1;
                    end
                end
                UPDATE: begin
                    state_q   <= IDLE;
                    fill_en_q <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    mem_read_q <= 1'b0;
                    fill_en_q  <= 1'b0;
                end
            endcase
        end
    end

    assign state    = state_q;
    assign mem_read = mem_read_q;
    assign fill_en  = fill_en_q;

endmodule

// File: rtl/ins_cache.sv
// Direct-mapped read-only instruction cache: 8 lines of 128 bits, zero-stall hits.
module ins_cache
    import ins_cache_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read,
    input  logic [ADDR_BITS-1:0]     address,
    output logic [WORD_BITS-1:0]     instruction,
    output logic                     busywait,
    output logic                     mem_read,
    output logic [MEM_ADDR_BITS-1:0] mem_address,
    input  logic [BLOCK_BITS-1:0]    mem_readdata,
    input  logic                     mem_busywait
);

    logic [TAG_BITS-1:0]    tag;
    logic [INDEX_BITS-1:0]  index;
    logic [OFFSET_BITS-1:0] offset;
    logic                   unused_addr_bits;

    assign tag              = address[TAG_LSB +: TAG_BITS];
    assign index            = address[INDEX_LSB +: INDEX_BITS];
    assign offset           = address[OFFSET_LSB +: OFFSET_BITS];
    assign unused_addr_bits = ^address[OFFSET_LSB-1:0];

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
    block_t                data_q [NUM_BLOCKS];
    logic [TAG_BITS-1:0]   miss_tag_q;
    logic [INDEX_BITS-1:0] miss_index_q;

    state_e state;
    logic   hit;
    logic   latch_miss;
    logic   fill_en;

    assign hit = read & valid_q[index] & (tag_q[index] == tag);

    ins_cache_fsm u_fsm (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .hit          (hit),
        .mem_busywait (mem_busywait),
        .state        (state),
        .mem_read     (mem_read),
        .latch_miss   (latch_miss),
        .fill_en      (fill_en)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (latch_miss) begin
                miss_tag_q   <= tag;
                miss_index_q <= index;
            end
            if (fill_en) begin
                data_q[miss_index_q]  <= mem_readdata;
                tag_q[miss_index_q]   <= miss_tag_q;
                valid_q[miss_index_q] <= 1'b1;
            end
        end
    end

    assign instruction = data_q[index][offset];
    assign busywait    = (read & ~hit) | (state != IDLE);
    assign mem_address = {miss_tag_q, miss_index_q};

endmodule
